fetch_issue_ctrl: RTL and testbench

Front-end controller for the combinational instruction ROM: owns the PC, drives the ROM address, and captures {SSSrc, RD} into a small circular fetch queue. It issues one or two instructions per cycle to decode. The SSSrc bit marks an instruction that must dual-issue with its successor. The block also handles branch redirects, decode back-pressure and a halt/drain sequence.

---
 rtl/fetch_pkg.sv | 38 +++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_issue_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch/issue front end.
//   RESET_PC_DEF  : default first fetch address
//   fetch_state_e : controller states
//   fq_entry_t    : fetch-queue payload {sss, instr, pc}
//   pop_e         : number of queue entries retired by one issue
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_1000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic        sss;
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

    // Entry count retired by a pop code.
    function automatic logic [1:0] pop_amount(input pop_e p);
        case (p)
            POP_ONE: return 2'd1;
            POP_TWO: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue holding QDEPTH entries.
//   clk_i, reset_i    : clock, synchronous active-high reset
//   flush_i           : drop every entry (wins over push/pop)
//   push_i/entry_i    : write one entry at the tail (caller guarantees space)
//   pop_i             : retire 0, 1 or 2 entries from the head
//   head_o            : entry at head
//   next_instr_o/pc_o : entry after head (its sss flag is never needed)
//   count_o           : occupancy 0..QDEPTH
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fq_entry_t                push_entry_i,
    input  pop_e                     pop_i,
    output fq_entry_t                head_o,
    output logic [31:0]              next_instr_o,
    output logic [31:0]              next_pc_o,
    output logic [$clog2(QDEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fq_entry_t          mem_q [QDEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W-1:0]   next_idx;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         pop_n;

    // Pointer/occupancy update; pointers wrap naturally at PTR_W bits.
    always_comb begin
        pop_n   = pop_amount(pop_i);
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_i);
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_n);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i && !flush_i) begin
                mem_q[tail_q] <= push_entry_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign next_idx     = head_q + PTR_W'(1);
    assign head_o       = mem_q[head_q];
    assign next_instr_o = mem_q[next_idx].instr;
    assign next_pc_o    = mem_q[next_idx].pc;
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue controller: owns the PC, fetches from a combinational ROM into
// the fetch queue and issues one instruction, or an sss-marked pair, per cycle.
//   clk, reset                      : clock, synchronous active-high reset
//   imem_addr / imem_rd / imem_sssrc: ROM address and returned word/pair flag
//   issue_ready                     : decode accepts the current bundle
//   issue0_* / issue1_*             : issue slots (slot 1 only for pairs)
//   redirect_valid / redirect_pc    : branch/jump redirect
//   halt_req / halted               : drain request and drained status
//   fetch_cnt / pair_cnt            : wrapping performance counters
module fetch_issue_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_rd,
    input  logic              imem_sssrc,
    input  logic              issue_ready,
    output logic              issue0_valid,
    output logic [31:0]       issue0_instr,
    output logic [31:0]       issue0_pc,
    output logic              issue1_valid,
    output logic [31:0]       issue1_instr,
    output logic [31:0]       issue1_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  pair_cnt
);

    localparam int unsigned QCNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e       state_q;
    logic               halted_q;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
    fq_entry_t          head, push_entry;
    logic [31:0]        next_instr, next_pc;
    logic [QCNT_W-1:0]  count;
    logic               active, redir_en, fetch_en, issue_v0, issue_v1;
    pop_e               pop;

    // Fetch/issue decisions. A halt request also suppresses fetch in the
    // cycle it is seen, so only already-queued work drains.
    always_comb begin
        active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        redir_en = active && redirect_valid;
        fetch_en = (state_q == ST_RUN) && !redir_en && !halt_req
                   && (count < QCNT_W'(QDEPTH));
        issue_v0 = 1'b0;
        issue_v1 = 1'b0;
        if (active && !redirect_valid) begin
            if (head.sss) begin
                // A pair waits until both halves are queued; never split.
                issue_v0 = (count >= QCNT_W'(2));
                issue_v1 = issue_v0;
            end else begin
                issue_v0 = (count != '0);
            end
        end
        pop = POP_NONE;
        if (issue_v0 && issue_ready) begin
            pop = issue_v1 ? POP_TWO : POP_ONE;
        end
    end

    // PC and counter next-state.
    always_comb begin
        pc_d = pc_q;
        if (redir_en) begin
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (fetch_en) begin
            pc_d = pc_q + 32'd4;
        end
        fetch_cnt_d = fetch_cnt_q + CNT_W'(fetch_en);
        pair_cnt_d  = pair_cnt_q + CNT_W'(pop == POP_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
            pair_cnt_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end

    // Controller FSM with registered halted flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (halt_req) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_valid || (count == '0)) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: halted_q <= 1'b1;
                default:   state_q  <= ST_BOOT;
            endcase
        end
    end

    assign push_entry = '{sss: imem_sssrc, instr: imem_rd, pc: pc_q};

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk_i        (clk),
        .reset_i      (reset),
        .flush_i      (redir_en),
        .push_i       (fetch_en),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .next_instr_o (next_instr),
        .next_pc_o    (next_pc),
        .count_o      (count)
    );

    assign imem_addr    = pc_q;
    assign issue0_valid = issue_v0;
    assign issue0_instr = issue_v0 ? head.instr : '0;
    assign issue0_pc    = issue_v0 ? head.pc    : '0;
    assign issue1_valid = issue_v1;
    assign issue1_instr = issue_v1 ? next_instr : '0;
    assign issue1_pc    = issue_v1 ? next_pc    : '0;
    assign halted       = halted_q;
    assign fetch_cnt    = fetch_cnt_q;
    assign pair_cnt     = pair_cnt_q;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Bench for fetch_issue_ctrl: directed scenarios plus a randomized run, all
// checked cycle by cycle against a queue-based behavioural model.
module tb_fetch_issue_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam int          QDEPTH   = 4;
    localparam int          M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr, imem_rd;
    logic        imem_sssrc;
    logic        issue_ready = 1'b0;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue0_pc, issue1_instr, issue1_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic [31:0] fetch_cnt, pair_cnt;

    logic [31:0] rom_instr [64];
    bit          rom_sss   [64];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        sss;
        logic [31:0] instr;
        logic [31:0] pc;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_pc, m_fetch, m_pair;
    int          m_mode;
    bit          m_halted;

    fetch_issue_ctrl #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH),
        .CNT_W    (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .imem_sssrc     (imem_sssrc),
        .issue_ready    (issue_ready),
        .issue0_valid   (issue0_valid),
        .issue0_instr   (issue0_instr),
        .issue0_pc      (issue0_pc),
        .issue1_valid   (issue1_valid),
        .issue1_instr   (issue1_instr),
        .issue1_pc      (issue1_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt),
        .pair_cnt       (pair_cnt)
    );

    always #5 clk = ~clk;

    assign imem_rd    = rom_instr[imem_addr[7:2]];
    assign imem_sssrc = rom_sss[imem_addr[7:2]];

    // Model: which slots issue this cycle.
    function automatic void model_issue(output bit v0, output bit v1);
        v0 = 1'b0;
        v1 = 1'b0;
        if ((m_mode == M_RUN || m_mode == M_DRAIN) && !redirect_valid && mq.size() > 0) begin
            if (mq[0].sss) begin
                v0 = (mq.size() >= 2);
                v1 = v0;
            end else begin
                v0 = 1'b1;
            end
        end
    endfunction

    function automatic logic [226:0] model_vec();
        bit v0, v1;
        logic [31:0] i0 = '0, p0 = '0, i1 = '0, p1 = '0;
        model_issue(v0, v1);
        if (v0) begin i0 = mq[0].instr; p0 = mq[0].pc; end
        if (v1) begin i1 = mq[1].instr; p1 = mq[1].pc; end
        return {m_pc, v0, i0, p0, v1, i1, p1, m_halted, m_fetch, m_pair};
    endfunction

    function automatic logic [226:0] dut_vec();
        return {imem_addr, issue0_valid, issue0_instr, issue0_pc,
                issue1_valid, issue1_instr, issue1_pc, halted, fetch_cnt, pair_cnt};
    endfunction

    // Model: apply one clock edge using the current inputs.
    task automatic model_tick();
        bit v0, v1, redir, fetch;
        int n, sz;
        logic [5:0] idx;
        if (reset) begin
            mq.delete();
            m_pc = RESET_PC; m_mode = M_BOOT; m_halted = 1'b0; m_fetch = '0; m_pair = '0;
        end else begin
            model_issue(v0, v1);
            redir = redirect_valid && (m_mode == M_RUN || m_mode == M_DRAIN);
            n     = (v0 && issue_ready) ? (v1 ? 2 : 1) : 0;
            sz    = mq.size();
            fetch = (m_mode == M_RUN) && !redir && !halt_req && (sz < QDEPTH);
            case (m_mode)
                M_BOOT:  m_mode = M_RUN;
                M_RUN:   if (halt_req) m_mode = M_DRAIN;
                M_DRAIN: if (redir || sz == 0) m_mode = M_HALTED;
                default: m_mode = M_HALTED;
            endcase
            m_halted = (m_mode == M_HALTED);
            if (redir) begin
                mq.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                for (int k = 0; k < n; k++) void'(mq.pop_front());
                if (n == 2) m_pair = m_pair + 1;
                if (fetch) begin
                    idx = m_pc[7:2];
                    mq.push_back('{sss: rom_sss[idx], instr: rom_instr[idx], pc: m_pc});
                    m_pc    = m_pc + 32'd4;
                    m_fetch = m_fetch + 1;
                end
            end
        end
    endtask

    task automatic advance();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; issue_ready = 1'b0;
        @(negedge clk);
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        advance();
        advance();
        @(negedge clk);
        checks++;
        if (dut_vec() !== {32'h1000, 195'd0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), {32'h1000, 195'd0});
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL reset_model got=%h exp=%h", dut_vec(), model_vec());
        end
        advance();
    endtask

    task automatic test_latency();
        do_reset();
        issue_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL latency_c%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
            if (c < 2) begin
                checks++;
                if (issue0_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL latency_early_valid c%0d got=%b exp=0", c, issue0_valid);
                end
            end
            if (c == 2) begin
                checks++;
                if ({issue0_valid, issue0_instr, issue0_pc} !== {1'b1, 32'hFFC4A303, 32'h1000}) begin
                    failures++;
                    $display("FAIL latency_first got=%h exp=%h",
                             {issue0_valid, issue0_instr, issue0_pc}, {1'b1, 32'hFFC4A303, 32'h1000});
                end
            end
            if (c == 5) begin
                checks++;
                if (fetch_cnt !== 32'd4) begin
                    failures++;
                    $display("FAIL latency_fetch_cnt got=%0d exp=4", fetch_cnt);
                end
            end
            checks++;
            if (issue1_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_no_pair c%0d got=%b exp=0", c, issue1_valid);
            end
            advance();
        end
    endtask

    task automatic test_pair();
        bit saw_pair = 1'b0;
        rom_sss[1] = 1'b1;
        do_reset();
        issue_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL pair_c%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
            if (issue1_valid === 1'b1) begin
                saw_pair = 1'b1;
                checks++;
                if ({issue0_pc, issue1_pc, issue1_instr} !== {32'h1004, 32'h1008, 32'h0062E233}) begin
                    failures++;
                    $display("FAIL pair_slots got=%h exp=%h", {issue0_pc, issue1_pc, issue1_instr},
                             {32'h1004, 32'h1008, 32'h0062E233});
                end
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (!saw_pair || pair_cnt !== 32'd1) begin
            failures++;
            $display("FAIL pair_cnt got=%0d seen=%0d exp=1", pair_cnt, saw_pair);
        end
        advance();
        rom_sss[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c == 11) issue_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL bp_c%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
            if (c >= 2 && c <= 11) begin
                checks++;
                if ({issue0_valid, issue0_instr, issue0_pc, issue1_valid} !==
                    {1'b1, 32'hFFC4A303, 32'h1000, 1'b0}) begin
                    failures++;
                    $display("FAIL bp_stable c%0d got=%h", c, {issue0_valid, issue0_instr, issue0_pc});
                end
            end
            if (c == 10) begin
                checks++;
                if (imem_addr !== 32'h1010) begin
                    failures++;
                    $display("FAIL bp_addr got=%h exp=00001010", imem_addr);
                end
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            redirect_valid = (c == 4);
            redirect_pc    = 32'h1003;
            issue_ready    = (c >= 5);
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL redir_c%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
            if (c == 4 && {issue0_valid, issue1_valid} !== 2'b00) begin
                failures++;
                $display("FAIL redir_kill got=%b exp=00", {issue0_valid, issue1_valid});
            end
            if (c == 5 && {imem_addr, issue0_valid} !== {32'h1000, 1'b0}) begin
                failures++;
                $display("FAIL redir_next got=%h exp=%h", {imem_addr, issue0_valid}, {32'h1000, 1'b0});
            end
            if (c == 6 && {issue0_valid, issue0_pc} !== {1'b1, 32'h1000}) begin
                failures++;
                $display("FAIL redir_resume got=%h exp=%h", {issue0_valid, issue0_pc}, {1'b1, 32'h1000});
            end
            if (c >= 4 && c <= 6) checks++;
            advance();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_halt();
        int issued = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            halt_req    = (c == 4);
            issue_ready = (c >= 4);
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL halt_c%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
            if (issue0_valid && issue_ready) issued += issue1_valid ? 2 : 1;
            advance();
        end
        @(negedge clk);
        checks++;
        if ({issued[7:0], halted, imem_addr} !== {8'd3, 1'b1, 32'h100C}) begin
            failures++;
            $display("FAIL halt_drain got=%h exp=%h", {issued[7:0], halted, imem_addr}, {8'd3, 1'b1, 32'h100C});
        end
        advance();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        @(negedge clk);
        advance();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({halted, imem_addr, issue0_valid} !== {1'b1, 32'h100C, 1'b0}) begin
            failures++;
            $display("FAIL halt_redirect got=%h exp=%h", {halted, imem_addr, issue0_valid}, {1'b1, 32'h100C, 1'b0});
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL halt_model got=%h exp=%h", dut_vec(), model_vec());
        end
        advance();
    endtask

    task automatic test_midreset();
        rom_sss[0] = 1'b1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            reset = (c == 6);
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL midrst_c%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
            if (c == 5) begin
                checks++;
                if ({issue0_valid, issue1_valid, fetch_cnt} !== {2'b11, 32'd4}) begin
                    failures++;
                    $display("FAIL midrst_full got=%h exp=%h", {issue0_valid, issue1_valid, fetch_cnt}, {2'b11, 32'd4});
                end
            end
            if (c == 7 || c == 8) begin
                checks++;
                if (dut_vec() !== {32'h1000, 195'd0}) begin
                    failures++;
                    $display("FAIL midrst_after c%0d got=%h exp=%h", c, dut_vec(), {32'h1000, 195'd0});
                end
            end
            advance();
        end
        reset = 1'b0;
        rom_sss[0] = 1'b0;
    endtask

    task automatic test_random();
        int hcnt = 0;
        for (int i = 0; i < 64; i++) begin
            rom_instr[i] = $urandom;
            rom_sss[i]   = ($urandom_range(0, 2) == 0);
        end
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            issue_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : (32'h1000 + 32'($urandom_range(0, 255)));
            halt_req       = ($urandom_range(0, 99) == 0);
            hcnt           = m_halted ? hcnt + 1 : 0;
            reset          = (hcnt > 4) || ($urandom_range(0, 499) == 0);
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL rand_c%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
            advance();
        end
        reset = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_instr[i] = $urandom;
            rom_sss[i]   = 1'b0;
        end
        rom_instr[0] = 32'hFFC4A303;
        rom_instr[1] = 32'h0064A423;
        rom_instr[2] = 32'h0062E233;
        rom_instr[3] = 32'hFE420AE3;
        test_reset();
        test_latency();
        test_pair();
        test_backpressure();
        test_redirect();
        test_halt();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
